// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet parser.
// Holds the FSM state encoding and the default framing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GET_LEN     = 2'd1,
        GET_PAYLOAD = 2'd2,
        GET_CHK     = 2'd3
    } state_e;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;
    localparam int         BUF_DEPTH    = 8;
    localparam int         IDX_W        = $clog2(BUF_DEPTH);

    function automatic logic len_in_range(
        input logic [7:0] len,
        input logic [7:0] max_len
    );
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/uart_packet_parser_if.sv
// Byte-stream input and packet/error output bundle of the parser.
// The parser takes the slave side; the UART/decoder side is master.
interface uart_packet_parser_if;

    logic        rx_data_ready;
    logic [7:0]  rx_data;
    logic        pkt_valid;
    logic [3:0]  pkt_len;
    logic [63:0] pkt_data;
    logic        len_err;
    logic        chk_err;
    logic        to_err;

    modport master (
        output rx_data_ready,
        output rx_data,
        input  pkt_valid,
        input  pkt_len,
        input  pkt_data,
        input  len_err,
        input  chk_err,
        input  to_err
    );

    modport slave (
        input  rx_data_ready,
        input  rx_data,
        output pkt_valid,
        output pkt_len,
        output pkt_data,
        output len_err,
        output chk_err,
        output to_err
    );

endinterface

// File: rtl/uart_timeout_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled.
// expired is high while enabled and the count sits at its last value.
module uart_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 20000,
    localparam int W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_packet_parser.sv
// Frames SOF,LEN,PAYLOAD[LEN],CHK packets from the UART byte stream.
// Good packets come out as one parallel word; bad ones pulse an error.
module uart_packet_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEF,
    parameter int         MAX_LEN        = 8,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_packet_parser_if.slave  bus
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e state_q;
    state_e state_d;

    logic [BUF_DEPTH-1:0][7:0] buf_q;
    logic [BUF_DEPTH-1:0][7:0] buf_d;
    logic [3:0]                idx_q;
    logic [3:0]                idx_d;
    logic [3:0]                len_q;
    logic [3:0]                len_d;
    logic [7:0]                sum_q;
    logic [7:0]                sum_d;

    logic                      pkt_valid_q;
    logic                      pkt_valid_d;
    logic [3:0]                pkt_len_q;
    logic [3:0]                pkt_len_d;
    logic [63:0]               pkt_data_q;
    logic [63:0]               pkt_data_d;
    logic                      len_err_q;
    logic                      len_err_d;
    logic                      chk_err_q;
    logic                      chk_err_d;
    logic                      to_err_q;
    logic                      to_err_d;

    logic                      byte_v;
    logic [7:0]                rx;
    logic                      len_ok;
    logic                      expired;
    logic                      timeout;
    logic                      tmr_clr;
    logic                      tmr_en;

    assign byte_v  = bus.rx_data_ready;
    assign rx      = bus.rx_data;
    assign len_ok  = len_in_range(rx, MAX_LEN_B);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout = expired && !byte_v;
    assign tmr_en  = (state_q != IDLE);
    assign tmr_clr = byte_v || (state_d == IDLE);

    uart_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (byte_v) begin
            unique case (state_q)
                IDLE: begin
                    if (rx == SOF_BYTE) state_d = GET_LEN;
                end
                GET_LEN: begin
                    state_d = len_ok ? GET_PAYLOAD : IDLE;
                end
                GET_PAYLOAD: begin
                    if (idx_q == len_q - 4'd1) state_d = GET_CHK;
                end
                GET_CHK: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        buf_d       = buf_q;
        idx_d       = idx_q;
        len_d       = len_q;
        sum_d       = sum_q;
        pkt_valid_d = 1'b0;
        pkt_len_d   = pkt_len_q;
        pkt_data_d  = pkt_data_q;
        len_err_d   = 1'b0;
        chk_err_d   = 1'b0;
        to_err_d    = timeout;
        if (byte_v) begin
            unique case (state_q)
                IDLE: begin
                    if (rx == SOF_BYTE) begin
                        buf_d = '0;
                        idx_d = '0;
                        sum_d = '0;
                    end
                end
                GET_LEN: begin
                    if (len_ok) begin
                        len_d = rx[3:0];
                        sum_d = rx;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
                GET_PAYLOAD: begin
                    buf_d[idx_q[IDX_W-1:0]] = rx;
                    idx_d = idx_q + 4'd1;
                    sum_d = sum_q + rx;
                end
                GET_CHK: begin
                    if (rx == sum_q) begin
                        pkt_valid_d = 1'b1;
                        pkt_len_d   = len_q;
                        pkt_data_d  = buf_q;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            pkt_valid_q <= 1'b0;
            pkt_len_q   <= '0;
            pkt_data_q  <= '0;
            len_err_q   <= 1'b0;
            chk_err_q   <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_len_q   <= pkt_len_d;
            pkt_data_q  <= pkt_data_d;
            len_err_q   <= len_err_d;
            chk_err_q   <= chk_err_d;
            to_err_q    <= to_err_d;
        end
    end

    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pkt_len   = pkt_len_q;
    assign bus.pkt_data  = pkt_data_q;
    assign bus.len_err   = len_err_q;
    assign bus.chk_err   = chk_err_q;
    assign bus.to_err    = to_err_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed bench for uart_packet_parser: framing, errors, timeout.
// Bytes are driven at negedges; outputs are checked at negedges.
module tb_uart_packet_parser;

    localparam int T = 20000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   pv_cnt;
    int   le_cnt;
    int   ce_cnt;
    int   te_cnt;
    int   ovl_cnt;

    uart_packet_parser_if bus ();

    uart_packet_parser #(
        .SOF_BYTE       (8'hA5),
        .MAX_LEN        (8),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sample a little after each negedge.
    always @(negedge clk) begin
        #2;
        if (bus.pkt_valid) pv_cnt++;
        if (bus.len_err) le_cnt++;
        if (bus.chk_err) ce_cnt++;
        if (bus.to_err) te_cnt++;
        if ((int'(bus.pkt_valid) + int'(bus.len_err)
             + int'(bus.chk_err) + int'(bus.to_err)) > 1)
            ovl_cnt++;
    end

    task automatic clr_cnt();
        @(negedge clk);
        #3;
        pv_cnt = 0;
        le_cnt = 0;
        ce_cnt = 0;
        te_cnt = 0;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #3;
    endtask

    // Must be entered at a negedge; returns at the next negedge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data_ready = 1'b1;
        bus.rx_data = b;
        @(negedge clk);
        bus.rx_data_ready = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_data_ready = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pkt_valid got %b want 0", bus.pkt_valid);
        end
        n_checks++;
        if (bus.pkt_len !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_pkt_len got %0d want 0", bus.pkt_len);
        end
        n_checks++;
        if (bus.pkt_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_pkt_data got %h want 0", bus.pkt_data);
        end
        n_checks++;
        if ({bus.len_err, bus.chk_err, bus.to_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_errs got %b want 000",
                     {bus.len_err, bus.chk_err, bus.to_err});
        end
    endtask

    task automatic test_good();
        clr_cnt();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h69);
        n_checks++;
        if (bus.pkt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL good_valid got %b want 1", bus.pkt_valid);
        end
        n_checks++;
        if (bus.pkt_len !== 4'd3) begin
            n_fail++;
            $display("FAIL good_len got %0d want 3", bus.pkt_len);
        end
        n_checks++;
        if (bus.pkt_data !== 64'h0000_0000_0033_2211) begin
            n_fail++;
            $display("FAIL good_data got %h want 332211", bus.pkt_data);
        end
        @(negedge clk);
        n_checks++;
        if (bus.pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_valid_width got %b want 0", bus.pkt_valid);
        end
        settle();
        n_checks++;
        if (pv_cnt !== 1 || le_cnt + ce_cnt + te_cnt !== 0) begin
            n_fail++;
            $display("FAIL good_pulses pv=%0d err=%0d want 1/0",
                     pv_cnt, le_cnt + ce_cnt + te_cnt);
        end
    endtask

    task automatic test_bad_chk();
        clr_cnt();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h00);
        n_checks++;
        if (bus.chk_err !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_err got %b want 1", bus.chk_err);
        end
        settle();
        n_checks++;
        if (ce_cnt !== 1 || pv_cnt !== 0) begin
            n_fail++;
            $display("FAIL chk_pulses ce=%0d pv=%0d want 1/0",
                     ce_cnt, pv_cnt);
        end
        n_checks++;
        if (bus.pkt_data !== 64'h0000_0000_0033_2211 ||
            bus.pkt_len !== 4'd3) begin
            n_fail++;
            $display("FAIL chk_hold got %h/%0d want 332211/3",
                     bus.pkt_data, bus.pkt_len);
        end
    endtask

    task automatic test_bad_len();
        clr_cnt();
        send_byte(8'hA5);
        send_byte(8'h00);
        n_checks++;
        if (bus.len_err !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_err got %b want 1", bus.len_err);
        end
        send_byte(8'hA5);
        send_byte(8'h09);
        n_checks++;
        if (bus.len_err !== 1'b1) begin
            n_fail++;
            $display("FAIL len9_err got %b want 1", bus.len_err);
        end
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'h00);
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_len !== 4'd1 ||
            bus.pkt_data !== 64'hFF) begin
            n_fail++;
            $display("FAIL len_follow got %b/%0d/%h want 1/1/ff",
                     bus.pkt_valid, bus.pkt_len, bus.pkt_data);
        end
        settle();
        n_checks++;
        if (le_cnt !== 2 || pv_cnt !== 1) begin
            n_fail++;
            $display("FAIL len_pulses le=%0d pv=%0d want 2/1",
                     le_cnt, pv_cnt);
        end
    endtask

    task automatic test_timeout();
        int first;
        clr_cnt();
        first = -1;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        for (int k = 1; k <= T + 5; k++) begin
            @(negedge clk);
            if (bus.to_err && first < 0) first = k;
        end
        n_checks++;
        if (first !== T) begin
            n_fail++;
            $display("FAIL to_latency got %0d want %0d", first, T);
        end
        n_checks++;
        if (bus.pkt_data !== 64'hFF) begin
            n_fail++;
            $display("FAIL to_hold got %h want ff", bus.pkt_data);
        end
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h06);
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 64'h05) begin
            n_fail++;
            $display("FAIL to_follow got %b/%h want 1/05",
                     bus.pkt_valid, bus.pkt_data);
        end
        settle();
        n_checks++;
        if (te_cnt !== 1 || pv_cnt !== 1) begin
            n_fail++;
            $display("FAIL to_pulses te=%0d pv=%0d want 1/1",
                     te_cnt, pv_cnt);
        end
    endtask

    task automatic test_byte_at_timeout();
        clr_cnt();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        repeat (T - 1) @(negedge clk);
        send_byte(8'hBB);
        send_byte(8'h67);
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 64'hBBAA) begin
            n_fail++;
            $display("FAIL edge_pkt got %b/%h want 1/bbaa",
                     bus.pkt_valid, bus.pkt_data);
        end
        settle();
        n_checks++;
        if (te_cnt !== 0) begin
            n_fail++;
            $display("FAIL edge_to got %0d want 0", te_cnt);
        end
    endtask

    task automatic test_noise();
        clr_cnt();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_byte(8'h4C);
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_len !== 4'd2 ||
            bus.pkt_data !== 64'hA5A5) begin
            n_fail++;
            $display("FAIL noise_pkt got %b/%0d/%h want 1/2/a5a5",
                     bus.pkt_valid, bus.pkt_len, bus.pkt_data);
        end
        settle();
        n_checks++;
        if (le_cnt + ce_cnt + te_cnt !== 0) begin
            n_fail++;
            $display("FAIL noise_errs got %0d want 0",
                     le_cnt + ce_cnt + te_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clr_cnt();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h07);
        send_byte(8'h08);
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 64'h07) begin
            n_fail++;
            $display("FAIL rstmid_pkt got %b/%h want 1/07",
                     bus.pkt_valid, bus.pkt_data);
        end
        settle();
        n_checks++;
        if (le_cnt + ce_cnt + te_cnt !== 0) begin
            n_fail++;
            $display("FAIL rstmid_errs got %0d want 0",
                     le_cnt + ce_cnt + te_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clr_cnt();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h11);
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 64'h10) begin
            n_fail++;
            $display("FAIL b2b_first got %b/%h want 1/10",
                     bus.pkt_valid, bus.pkt_data);
        end
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h05);
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_len !== 4'd2 ||
            bus.pkt_data !== 64'h0201) begin
            n_fail++;
            $display("FAIL b2b_second got %b/%0d/%h want 1/2/0201",
                     bus.pkt_valid, bus.pkt_len, bus.pkt_data);
        end
        settle();
        n_checks++;
        if (pv_cnt !== 2) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 2", pv_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        ovl_cnt = 0;
        pv_cnt = 0;
        le_cnt = 0;
        ce_cnt = 0;
        te_cnt = 0;
        test_reset();
        test_good();
        test_bad_chk();
        test_bad_len();
        test_timeout();
        test_byte_at_timeout();
        test_noise();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (ovl_cnt !== 0) begin
            n_fail++;
            $display("FAIL overlap got %0d want 0", ovl_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_packet_parser.md
Name: uart_packet_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its one-cycle byte-ready pulse and 8-bit data.
- Assembles framed command packets of the form SOF, LEN, PAYLOAD[LEN], CHK.
- Checks length, checksum and inter-byte timeout, then presents each good packet to the command decoder as one parallel word with a single-cycle valid strobe.
- Discards malformed packets and reports them with error pulses.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 8, maximum payload bytes (1..8). The buffer is sized for 8.
- TIMEOUT_CYCLES, 20000, clock cycles allowed between consecutive bytes inside a frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_data_ready  input  1  one-cycle pulse: rx_data valid this cycle.
- rx_data  input  8  received byte.
- pkt_valid  output  1  one-cycle pulse: pkt_len/pkt_data hold a verified packet.
- pkt_len  output  4  payload length of the last good packet (1..8).
- pkt_data  output  64  payload of the last good packet. Byte i is at [8i+7:8i]; unused bytes are 0.
- len_err  output  1  one-cycle pulse: LEN is 0 or greater than MAX_LEN.
- chk_err  output  1  one-cycle pulse: checksum mismatch.
- to_err  output  1  one-cycle pulse: inter-byte timeout expired.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high. All outputs and state are registered.
- Reset values: all outputs 0, state IDLE, buffer 0, byte index 0, running sum 0, timer 0.
- Reset mid-frame aborts the frame silently (no error pulse).
- A byte is consumed only in a cycle where rx_data_ready=1. All other cycles only advance the timer.
- FSM states: IDLE, GET_LEN, GET_PAYLOAD, GET_CHK.
- IDLE:
  - A byte equal to SOF_BYTE moves to GET_LEN, clears the buffer, index and sum.
  - Any other byte is dropped with no error.
- GET_LEN:
  - If LEN is 0 or greater than MAX_LEN: len_err pulses and the FSM returns to IDLE.
  - Otherwise LEN is latched, sum = LEN, and the FSM moves to GET_PAYLOAD.
- GET_PAYLOAD:
  - Each byte is written to buffer[index], index increments, and sum = sum + byte (mod 256).
  - After the LEN-th byte the FSM moves to GET_CHK.
  - SOF_BYTE appearing here is ordinary data; there is no resync.
- GET_CHK:
  - If the byte equals sum[7:0]: next cycle pkt_valid=1, pkt_len=LEN, pkt_data=buffer.
  - Otherwise chk_err pulses.
  - Both cases return to IDLE.
- Latency: pkt_valid, len_err and chk_err assert exactly 1 cycle after the rx_data_ready cycle that carried the deciding byte. Each is high for exactly 1 cycle.
- pkt_len and pkt_data update only on pkt_valid and hold until the next good packet. Error packets never disturb them.
- Timer:
  - Runs only outside IDLE.
  - Clears on every accepted byte and on entry to IDLE.
  - Increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no byte that cycle, to_err pulses and the FSM returns to IDLE.
- Simultaneous byte and timeout in the same cycle: the byte wins. It is consumed and the timer clears.
- Back-to-back packets: an SOF arriving the cycle after the CHK byte is accepted normally.
- The error pulses are mutually exclusive, and pkt_valid never coincides with any of them.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants for IDLE, GET_LEN, GET_PAYLOAD and GET_CHK;
  - the default SOF_BYTE value 8'hA5;
  - the buffer depth constant 8.
- One sub-module, uart_timeout_timer: clk, rst, clr, en, expired. Counter width is $clog2(TIMEOUT_CYCLES). It is instantiated once.

Test Plan:
1. Good packet: send A5,03,11,22,33,69 → one cycle after the 69 byte, pkt_valid=1, pkt_len=3, pkt_data=64'h0000_0000_0033_2211. No error pulses.
2. Bad checksum: send A5,02,10,20,00 → chk_err pulses once. pkt_valid stays 0 and pkt_data keeps its previous value.
3. Bad length: send A5,00, then separately A5,09 → len_err pulses once for each. Follow-up with A5,01,FF,00 → pkt_valid, pkt_len=1, pkt_data=64'hFF.
4. Timeout: send A5,02,AA, then idle for TIMEOUT_CYCLES → to_err pulses once and the FSM returns to IDLE. A fresh A5,01,05,06 → pkt_valid with pkt_data=64'h05.
5. Noise and in-payload SOF: send 00,FF,A5,02,A5,A5,4C → the leading noise is ignored, then pkt_valid with pkt_len=2 and pkt_data=64'hA5A5.
6. Reset mid-frame: send A5,04,01, assert rst for 1 cycle, then send A5,01,07,08 → no error pulse from the aborted frame, then pkt_valid with pkt_data=64'h07.
